// File: rtl/nn_param_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nn_param_streamer                                           |
// | Description : Responder for the nn parameter-load interface. On load_req  |
// |               it reads 8 bytes per pair from the byte-wide parameter ROM, |
// |               packs them into two big-endian 32-bit words and presents    |
// |               them as a paired register-file write (R2k, R2k+1) over a    |
// |               valid/ready handshake. A one-cycle load_done pulse follows  |
// |               the acceptance of the last pair.                            |
// |                                                                           |
// | Ports       : clk, reset        clock, synchronous active-high reset      |
// |               load_req          start pulse (sampled only when idle)      |
// |               busy, load_done   load in progress / completion pulse       |
// |               rom_en, rom_addr  ROM read strobe and byte address          |
// |               rom_data          ROM byte, valid one cycle after rom_en    |
// |               wr_valid/ready    register-file pair handshake              |
// |               wr_addr_even/odd  register indices 2k / 2k+1                |
// |               wr_data_even/odd  words 2k / 2k+1                           |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module nn_param_streamer #(
  parameter int DATAWIDTH  = 32,  // only 32 (4 bytes per word) is supported
  parameter int ROM_ADDR_W = 9,
  parameter int BASE_ADDR  = 8,
  parameter int NUM_WORDS  = 16,  // even, >= 2
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  output logic                  busy,
  output logic                  load_done,
  output logic                  rom_en,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [REG_ADDR_W-1:0] wr_addr_even,
  output logic [REG_ADDR_W-1:0] wr_addr_odd,
  output logic [DATAWIDTH-1:0]  wr_data_even,
  output logic [DATAWIDTH-1:0]  wr_data_odd
);

  localparam int NUM_PAIRS = NUM_WORDS / 2;
  localparam int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic [7:0]        byte_buf_q [8];
  logic [7:0]        byte_buf_d [8];

  // Next-state logic. The FETCH phase is one cycle longer than the number of
  // reads because the ROM returns each byte one cycle after its address.
  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    bcnt_d     = bcnt_q;
    byte_buf_d = byte_buf_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_FETCH;
          pair_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_FETCH: begin
        if (bcnt_q != 4'd0) begin
          byte_buf_d[3'(bcnt_q - 4'd1)] = rom_data;
        end
        if (bcnt_q == 4'd8) begin
          state_d = S_WRITE;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      S_WRITE: begin
        // Pair is held untouched until accepted; no reads happen meanwhile.
        if (wr_ready) begin
          if (pair_q == LAST_PAIR) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            pair_d  = pair_q + 1'b1;
            bcnt_d  = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pair_q  <= '0;
      bcnt_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        byte_buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      bcnt_q     <= bcnt_d;
      byte_buf_q <= byte_buf_d;
    end
  end

  // Outputs decode straight from registered state, so a reset clears them in
  // the very next cycle. Address sums are done at ROM_ADDR_W bits and wrap.
  always_comb begin
    busy      = (state_q != S_IDLE);
    load_done = (state_q == S_DONE);
    wr_valid  = (state_q == S_WRITE);
    rom_en    = (state_q == S_FETCH) && !bcnt_q[3];
    rom_addr  = '0;
    if (rom_en) begin
      rom_addr = ROM_ADDR_W'(BASE_ADDR) + ROM_ADDR_W'({pair_q, 3'b000}) +
                 ROM_ADDR_W'(bcnt_q);
    end
    wr_addr_even = '0;
    wr_addr_odd  = '0;
    wr_data_even = '0;
    wr_data_odd  = '0;
    if (wr_valid) begin
      wr_addr_even = REG_ADDR_W'({pair_q, 1'b0});
      wr_addr_odd  = REG_ADDR_W'({pair_q, 1'b1});
      // Lowest ROM address lands in the most significant byte.
      wr_data_even = {byte_buf_q[0], byte_buf_q[1], byte_buf_q[2], byte_buf_q[3]};
      wr_data_odd  = {byte_buf_q[4], byte_buf_q[5], byte_buf_q[6], byte_buf_q[7]};
    end
  end

endmodule
`default_nettype wire
